// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, RV32I width codes and request latch type.
package lsu_pkg;

  localparam int unsigned WordW = 32;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWrite  = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
  } req_ctl_t;

  // Width codes with no meaning for the given direction.
  function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
    end
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load sign/zero extension and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [WordW-1:0] rd_word,
  input  logic [WordW-1:0] old_word,
  input  logic [WordW-1:0] wdata,
  output logic [WordW-1:0] rdata,
  output logic [WordW-1:0] new_word
);

  always_comb begin
    rdata = rd_word;
    case (funct3)
      F3_B:    rdata = {{24{rd_word[7]}}, rd_word[7:0]};
      F3_H:    rdata = {{16{rd_word[15]}}, rd_word[15:0]};
      F3_BU:   rdata = {24'b0, rd_word[7:0]};
      F3_HU:   rdata = {16'b0, rd_word[15:0]};
      default: rdata = rd_word;
    endcase
  end

  // Memory only writes whole words, so the untouched upper bytes come from the read.
  always_comb begin
    new_word = wdata;
    case (funct3)
      F3_B:    new_word = {old_word[31:8], wdata[7:0]};
      F3_H:    new_word = {old_word[31:16], wdata[15:0]};
      default: new_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM driving a word-wide byte-addressed memory port.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses with resp_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WordW-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WordW-1:0]  resp_rdata,
  output logic              resp_err,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WordW-1:0]  mem_wr_data,
  input  logic [WordW-1:0]  mem_rd_data
);

  logic [1:0]        state_q, state_d;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WordW-1:0]  wr_data_q;
  logic [WordW-1:0]  rdata_q;
  logic              err_q;

  logic              accept;
  logic              misalign;
  logic              bad_req;
  logic [WordW-1:0]  ld_data;
  logic [WordW-1:0]  merged;

  assign req_ready   = (state_q == StIdle);
  assign accept      = req_valid && req_ready;
  assign resp_valid  = (state_q == StResp);
  // Decoded straight from the async-reset state so reset kills the strobe immediately.
  assign mem_wr_en   = (state_q == StWrite);
  assign mem_addr    = addr_q;
  assign mem_wr_data = wr_data_q;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: misalign = req_addr[0];
      F3_W:        misalign = |req_addr[1:0];
      default:     misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign bad_req = f3_illegal(req_we, req_funct3) || misalign;

  lsu_align u_align (
    .funct3   (ctl_q.funct3),
    .rd_word  (mem_rd_data),
    .old_word (mem_rd_data),
    .wdata    (wr_data_q),
    .rdata    (ld_data),
    .new_word (merged)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (bad_req) begin
            state_d = StResp;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = StWrite;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: state_d = ctl_q.we ? StWrite : StResp;
      StWrite:  state_d = StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q     <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        ctl_q.we     <= req_we;
        ctl_q.funct3 <= req_funct3;
        addr_q       <= req_addr;
        wr_data_q    <= req_wdata;
        rdata_q      <= '0;
        err_q        <= bad_req;
      end
      if (state_q == StAccess) begin
        if (ctl_q.we) begin
          wr_data_q <= merged;
        end else begin
          rdata_q <= ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-array memory, reference model at issue, monitor at negedge.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int AW    = 10;
  localparam int MEMSZ = 1024;
  localparam int P     = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data, mem_rd_data;

  always #(P / 2) clk = ~clk;

  lsu_ctrl #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  logic [7:0] mem     [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];

  assign mem_rd_data = {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                        mem[mem_addr + 10'd1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < 4; i++) mem[mem_addr + 10'(i)] <= mem_wr_data[8*i +: 8];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            lat;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  time   acc_t;
  int    checks = 0;
  int    errors = 0;
  int    stall_next = 0;
  int    stall_left = 0;
  bit    seen = 0;
  bit    expect_idle = 0;
  int    done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
  endtask

  function automatic int cycles_since_accept();
    return int'(($time - acc_t + P / 2) / P);
  endfunction

  // Reference model: access width in bytes is 1 << funct3[1:0]; bit 2 selects zero extension.
  task automatic model(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, input bit abort);
    logic [31:0]   old, mask, val, nw;
    logic [AW-1:0] ix;
    int            size;
    bit            bad;
    resp_t         r;
    wr_t           w;
    for (int k = 0; k < 4; k++) begin
      ix = a + AW'(k);
      old[8*k +: 8] = ref_mem[ix];
    end
    size = 1 << f3[1:0];
    bad  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
`ifdef LSU_MISALIGN_TRAP_EN
    if (!bad && (int'(a) % size) != 0) bad = 1;
`endif
    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (bad) begin
      r = '{rdata: 32'd0, err: 1'b1, lat: 1};
    end else if (!we) begin
      val = old & mask;
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      r = '{rdata: val, err: 1'b0, lat: 2};
    end else begin
      nw = (old & ~mask) | (wd & mask);
      w  = '{addr: a, data: nw, lat: (size == 4) ? 1 : 2};
      wq.push_back(w);
      r = '{rdata: 32'd0, err: 1'b0, lat: (size == 4) ? 2 : 3};
      if (!abort) begin
        for (int k = 0; k < 4; k++) begin
          ix = a + AW'(k);
          ref_mem[ix] = nw[8*k +: 8];
        end
      end
    end
    if (!abort) rq.push_back(r);
  endtask

  // Monitor: checks writes and responses, and drives resp_ready (with optional stall).
  always @(negedge clk) begin : mon
    resp_t r;
    wr_t   w;
    if (rst_n) begin
      if (expect_idle) begin
        chk("idle_after_handshake", {30'b0, req_ready, resp_valid}, 32'h2);
        expect_idle = 0;
      end
      if (mem_wr_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_data", mem_wr_data, w.data);
          chk("wr_latency", 32'(cycles_since_accept()), 32'(w.lat));
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
          resp_ready = 1'b1;
        end else begin
          r = rq[0];
          if (!seen) begin
            seen = 1;
            chk("resp_latency", 32'(cycles_since_accept()), 32'(r.lat));
            stall_left = stall_next;
          end
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", 32'(resp_err), 32'(r.err));
          chk("req_ready_busy", 32'(req_ready), 32'd0);
          if (stall_left > 0) begin
            resp_ready = 1'b0;
            stall_left--;
          end else begin
            resp_ready = 1'b1;
            void'(rq.pop_front());
            seen = 0;
            expect_idle = 1;
            done_cnt++;
          end
        end
      end else begin
        resp_ready = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, input int stall);
    int n;
    int target;
    wait_idle();
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    target     = done_cnt + 1;
    stall_next = stall;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    acc_t = $time;
    model(we, f3, a, wd, 0);
    #1;
    // Keep a junk request asserted while busy; it must be ignored.
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = AW'($urandom);
    req_wdata  = $urandom;
    n = 0;
    while (done_cnt < target && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (done_cnt < target) chk("resp_timeout", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    logic [7:0]    b;
    logic [AW-1:0] ra;
    int            n;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < MEMSZ; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    mem[32'h20] = 8'h80; mem[32'h21] = 8'hFF; mem[32'h22] = 8'h12; mem[32'h23] = 8'h34;
    ref_mem[32'h20] = 8'h80; ref_mem[32'h21] = 8'hFF;
    ref_mem[32'h22] = 8'h12; ref_mem[32'h23] = 8'h34;

    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, F3_W, 10'h010, 32'hDEAD_BEEF, 0);
    issue(1'b0, F3_W, 10'h010, 32'h0, 0);
    issue(1'b1, F3_B, 10'h010, 32'h0000_00AA, 0);
    issue(1'b0, F3_W, 10'h010, 32'h0, 0);
    issue(1'b0, F3_B, 10'h020, 32'h0, 0);
    issue(1'b0, F3_BU, 10'h020, 32'h0, 0);
    issue(1'b0, F3_H, 10'h020, 32'h0, 0);
    issue(1'b0, F3_HU, 10'h020, 32'h0, 0);
    issue(1'b1, 3'b011, 10'h030, 32'h1234_5678, 0);
    issue(1'b1, F3_W, 10'h031, 32'hCAFE_F00D, 0);
    issue(1'b0, F3_W, 10'h031, 32'h0, 0);
    issue(1'b1, F3_H, 10'h022, 32'hFFFF_5AA5, 0);
    issue(1'b0, F3_W, 10'h020, 32'h0, 5);
    issue(1'b1, F3_W, 10'h3FE, 32'h0102_0304, 0);
    issue(1'b0, F3_W, 10'h3FE, 32'h0, 0);
    issue(1'b0, 3'b111, 10'h000, 32'h0, 2);

    // Reset during the WRITE cycle of an SH: the store must be abandoned.
    wait_idle();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_H;
    req_addr   = 10'h040;
    req_wdata  = 32'h5555_AAAA;
    @(posedge clk);
    acc_t = $time;
    model(1'b1, F3_H, 10'h040, 32'h5555_AAAA, 1);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_write", 32'(mem_wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midop_reset");
    rq.delete();
    wq.delete();
    seen = 0;
    expect_idle = 0;
    stall_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, F3_W, 10'h040, 32'h0, 0);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 3) == 0) ra = AW'(1020 + $urandom_range(0, 3));
      else ra = AW'(16 + $urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
